// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  // IDLE: nothing outstanding; BUSY: one live request outstanding;
  // DROP: one request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Instruction addresses are always word aligned; low bits are discarded.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, inst} entries between memory return and decode.
// Latency: push -> o_vld one cycle (outputs come from registered storage, no bypass).
// Backpressure: none internally; the producer must never push into a full queue
//   unless it pops in the same cycle. i_flush empties the queue and wins over push/pop.
// Ports: i_push/i_push_dat write side, i_pop read side, o_vld/o_head queue head,
//   o_cnt current occupancy.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INST_W + ADDR_W,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  // Pointers and count are the only state that needs reset; the storage
  // array is never observed while empty because the head is gated by o_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_vld  = (r_cnt != '0);
  assign o_head = o_vld ? r_mem[r_rd_ptr] : '0;
  assign o_cnt  = r_cnt;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    (i_push && !i_pop && !i_flush) |-> (r_cnt != CW'(DEPTH)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    i_pop |-> (r_cnt != '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues word reads over req/gnt/rvalid,
//   queues {pc, inst} and hands them to decode over inst_valid/inst_ready.
// Latency: rvalid -> inst_valid one cycle; back-to-back requests sustain one per cycle.
// Backpressure: a request is only raised when the queue is guaranteed a free slot
//   for its response; redirect flushes the queue and drops any stale response.
// Ports: clk/rst_n; imem_* memory read port; inst_* decode port; redirect/redirect_pc.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc;     // PC of the request currently outstanding

  logic              w_push;
  logic              w_pop;
  logic              w_gnt;
  logic              w_slot;
  logic              w_credit_ok;
  logic [CW-1:0]     w_cnt;
  logic [CW:0]       w_occ_nxt;
  logic [INST_W+ADDR_W-1:0] w_head;

  // Responses only count while BUSY; anything arriving in IDLE or DROP is stale.
  assign w_push = (r_state == BUSY) && imem_rvalid && !redirect;
  assign w_pop  = inst_valid && inst_ready;

  // Occupancy at the end of this cycle; one extra slot must be free for the
  // response of any request granted now.
  assign w_occ_nxt   = {1'b0, w_cnt} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_credit_ok = (w_occ_nxt < (CW+1)'(DEPTH));

  // A new request may overlap only with the cycle that retires the previous one.
  assign w_slot = (r_state == IDLE) || ((r_state == BUSY) && imem_rvalid);

  // rst_n gating keeps req low while reset is held even though the state is IDLE.
  assign imem_req  = rst_n && w_slot && !redirect && w_credit_ok;
  assign imem_addr = r_fetch_pc;
  assign w_gnt     = imem_req && imem_gnt;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = word_align(redirect_pc);
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        BUSY:    w_state_nxt = imem_rvalid ? IDLE : DROP;
        DROP:    w_state_nxt = imem_rvalid ? IDLE : DROP;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            w_state_nxt    = BUSY;
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          end
        end
        BUSY: begin
          if (imem_rvalid) begin
            if (w_gnt) begin
              w_state_nxt    = BUSY;
              w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        DROP: begin
          if (imem_rvalid) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_gnt) r_req_pc <= r_fetch_pc;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat ({r_req_pc, imem_rdata}),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_vld      (inst_valid),
    .o_head     (w_head),
    .o_cnt      (w_cnt)
  );

  assign inst    = w_head[INST_W-1:0];
  assign inst_pc = w_head[INST_W+ADDR_W-1:INST_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, redirect, grant stall,
//   alignment/wrap and mid-stream reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rst_n_b;
  logic        imem_req_b;
  logic [31:0] imem_addr_b;
  logic        imem_gnt_b;
  logic        imem_rvalid_b;
  logic [31:0] imem_rdata_b;
  logic        inst_valid_b;
  logic [31:0] inst_b;
  logic [31:0] inst_pc_b;

  int passed = 0;
  int total  = 0;

  int lat = 1;
  int pend = 0;
  logic [31:0] pend_addr;
  logic [31:0] grants[$];
  logic [31:0] got[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_gnt(imem_gnt_b),
    .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b),
    .inst_valid(inst_valid_b), .inst(inst_b), .inst_pc(inst_pc_b), .inst_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: returns ~addr 'lat' cycles after the grant edge. Also logs
  // grants and decode handshakes late in each cycle, when everything is settled.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ~pend_addr;
        end
      end
      #7;
      if (rst_n) begin
        if (imem_req && imem_gnt) begin
          pend      = lat;
          pend_addr = imem_addr;
          grants.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) got.push_back(inst_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench at 2 time units into the first cycle after release.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    grants.delete();
    got.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else passed++;
    total++; if (inst !== 32'h0) $display("FAIL reset_inst got %h want 0", inst); else passed++;
    total++; if (inst_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", inst_pc); else passed++;
    total++; if (imem_req_b !== 1'b0) $display("FAIL reset_req_b got %b want 0", imem_req_b); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    imem_gnt = 1'b1; inst_ready = 1'b1; lat = 1;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*j))
        $display("FAIL stream_req c%0d got req=%b addr=%h want req=1 addr=%h", j, imem_req, imem_addr, 32'(4*j));
      else passed++;
      if (j < 2) begin
        total++; if (inst_valid !== 1'b0) $display("FAIL stream_early_valid c%0d got %b want 0", j, inst_valid); else passed++;
      end else begin
        exp_pc = 32'(4*(j-2));
        total++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== ~exp_pc)
          $display("FAIL stream_out c%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", j, inst_valid, inst_pc, inst, exp_pc, ~exp_pc);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    imem_gnt = 1'b1; inst_ready = 1'b0; lat = 1;
    do_reset();
    for (int j = 0; j < 6; j++) tick();
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL bp_req_stop got %b want 0", imem_req); else passed++;
    total++; if (grants.size() != 4) $display("FAIL bp_grant_count got %0d want 4", grants.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) begin
        total++; if (grants[i] !== 32'(4*i)) $display("FAIL bp_grant_addr %0d got %h want %h", i, grants[i], 32'(4*i)); else passed++;
      end
    end
    grants.delete();
    tick();
    inst_ready = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL bp_resume got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*i))
        $display("FAIL bp_drain %0d got v=%b pc=%h want v=1 pc=%h", i, inst_valid, inst_pc, 32'(4*i));
      else passed++;
    end
  endtask

  task automatic test_redirect();
    imem_gnt = 1'b1; inst_ready = 1'b1; lat = 2;
    do_reset();
    for (int j = 0; j < 5; j++) tick();   // now in cycle 5, grant of 0x8 was at end of cycle 4
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL redir_req got %b want 0", imem_req); else passed++;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4)
      $display("FAIL redir_head got v=%b pc=%h want v=1 pc=00000004", inst_valid, inst_pc);
    else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (dut.r_state !== DROP) $display("FAIL redir_state got %0d want %0d", dut.r_state, DROP); else passed++;
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL redir_drop got req=%b v=%b want req=0 v=0", imem_req, inst_valid);
    else passed++;
    tick();
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL redir_target got req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr);
    else passed++;
    for (int j = 0; j < 3; j++) tick();
    #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== ~32'h40)
      $display("FAIL redir_first got v=%b pc=%h inst=%h want v=1 pc=00000040 inst=%h", inst_valid, inst_pc, inst, ~32'h40);
    else passed++;
    tick();
    total++; if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h40)
      $display("FAIL redir_order got n=%0d first=%h,%h,%h want 3 entries 0,4,40", got.size(),
               (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx, (got.size() > 2) ? got[2] : 32'hx);
    else passed++;
  endtask

  task automatic test_gnt_stall();
    imem_gnt = 1'b0; inst_ready = 1'b1; lat = 1;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dut.r_fetch_pc !== 32'h0)
        $display("FAIL stall_hold c%0d got req=%b addr=%h pc=%h want req=1 addr=0 pc=0", j, imem_req, imem_addr, dut.r_fetch_pc);
      else passed++;
    end
    tick();
    imem_gnt = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL stall_gnt got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    else passed++;
    tick();
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL stall_next got req=%b addr=%h want req=1 addr=00000004", imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_align_wrap();
    imem_gnt = 1'b0; inst_ready = 1'b1; lat = 1;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h43;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL align_req_drop got %b want 0", imem_req); else passed++;
    tick();
    redirect = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL align_addr got req=%b addr=%h want req=1 addr=00000040", imem_req, imem_addr);
    else passed++;

    imem_gnt_b = 1'b1;
    rst_n_b = 1'b1;
    #1;
    total++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'hFFFF_FFFC)
      $display("FAIL wrap_first got req=%b addr=%h want req=1 addr=fffffffc", imem_req_b, imem_addr_b);
    else passed++;
    tick();
    imem_rvalid_b = 1'b1; imem_rdata_b = 32'h1234_5678;
    #1;
    total++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'h0)
      $display("FAIL wrap_second got req=%b addr=%h want req=1 addr=00000000", imem_req_b, imem_addr_b);
    else passed++;
    tick();
    imem_rvalid_b = 1'b0; imem_gnt_b = 1'b0;
    #1;
    total++; if (inst_valid_b !== 1'b1 || inst_pc_b !== 32'hFFFF_FFFC || inst_b !== 32'h1234_5678)
      $display("FAIL wrap_out got v=%b pc=%h inst=%h want v=1 pc=fffffffc inst=12345678", inst_valid_b, inst_pc_b, inst_b);
    else passed++;
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1'b1; inst_ready = 1'b0; lat = 1;
    do_reset();
    tick();
    tick();
    tick();
    imem_gnt = 1'b0;   // three grants only: 0x0, 0x4, 0x8
    tick();
    #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'hC)
      $display("FAIL mid_pre got v=%b pc=%h req=%b addr=%h want v=1 pc=0 req=1 addr=c", inst_valid, inst_pc, imem_req, imem_addr);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_pc !== 32'h0 || inst !== 32'h0)
      $display("FAIL mid_async got v=%b req=%b pc=%h inst=%h want all 0", inst_valid, imem_req, inst_pc, inst);
    else passed++;
    imem_gnt = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
      $display("FAIL mid_restart got req=%b addr=%h v=%b want req=1 addr=0 v=0", imem_req, imem_addr, inst_valid);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b1; rst_n_b = 1'b1;
    imem_gnt = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt_b = 1'b0; imem_rvalid_b = 1'b0; imem_rdata_b = '0;
    #1;
    rst_n = 1'b0; rst_n_b = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_gnt_stall();
    test_align_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
